// File: rtl/sample_unpacker.sv
// Packed-sample decoder: buffers 48-bit packets of three nibble-interleaved words
// and replays the four 12-bit samples they carry, one per handshake, oldest first.
module sample_unpacker #(
  parameter int PKT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_word_1,
  input  logic [15:0]      in_word_2,
  input  logic [15:0]      in_word_3,
  output logic [11:0]      sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             sample_last,
  output logic [CNT_W-1:0] pkt_count,
  output logic             idle_drop
);

  localparam int AW = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
  localparam logic [AW-1:0]    PTR_ONE   = 1;
  localparam logic [AW:0]      OCC_ONE   = 1;
  localparam logic [AW:0]      OCC_FULL  = PKT_DEPTH[AW:0];
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [15:0]      IDLE_WORD = 16'h0001;

  // Entry layout is {in_word_1, in_word_2, in_word_3}
  logic [47:0]      mem_reg [PKT_DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      occ_reg;
  logic [1:0]       idx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             idle_drop_reg;

  logic        accept;
  logic        is_idle;
  logic        push;
  logic        pop_sample;
  logic        pop_entry;
  logic [47:0] head;
  logic [11:0] lane [4];

  assign in_ready     = (occ_reg < OCC_FULL);
  assign sample_valid = (occ_reg != '0);
  assign accept       = in_valid && in_ready;
  assign is_idle      = (in_word_1 == IDLE_WORD) && (in_word_2 == IDLE_WORD) &&
                        (in_word_3 == IDLE_WORD);
  assign push         = accept && !is_idle;
  assign pop_sample   = sample_valid && sample_ready;
  assign pop_entry    = pop_sample && (idx_reg == 2'd3);

  assign head = mem_reg[rd_ptr_reg];

  // Sample k gathers nibble k of each word, high word supplying the MSBs
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = {head[32 + 4*gi +: 4], head[16 + 4*gi +: 4], head[4*gi +: 4]};
    end
  endgenerate

  assign sample_out  = sample_valid ? lane[idx_reg] : 12'h000;
  assign sample_last = sample_valid && (idx_reg == 2'd3);
  assign pkt_count   = cnt_reg;
  assign idle_drop   = idle_drop_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= {in_word_1, in_word_2, in_word_3};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occ_reg       <= '0;
      idx_reg       <= 2'd0;
      cnt_reg       <= '0;
      idle_drop_reg <= 1'b0;
    end else begin
      idle_drop_reg <= accept && is_idle;
      if (accept) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_sample) begin
        idx_reg <= idx_reg + 2'd1;
      end
      if (pop_entry) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop_entry})
        2'b10:   occ_reg <= occ_reg + OCC_ONE;
        2'b01:   occ_reg <= occ_reg - OCC_ONE;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: doc/sample_unpacker.md
# sample_unpacker

Receiver-side decoder for the acquisition path's packed sample stream. Accepts one packet of three nibble-interleaved 16-bit words, which together carry four 12-bit ADC samples, and buffers it in a small packet FIFO. It then de-interleaves the packet and emits the four samples one per handshake, in acquisition order. It sits on the consumer end of the acquisition packer (for example, behind the UART/PSRAM link) and restores the original sample stream for post-processing.

## Interface
- PKT_DEPTH, 2, packet FIFO depth in packets; power of two, ≥2
- CNT_W, 16, width of the accepted-packet counter
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears FIFO, index, counter
- in_valid  in  1  packet present on in_word_1..3
- in_ready  out  1  block can accept a packet this cycle
- in_word_1  in  16  high nibbles: {s3[11:8], s2[11:8], s1[11:8], s0[11:8]}
- in_word_2  in  16  mid nibbles: {s3[7:4], s2[7:4], s1[7:4], s0[7:4]}
- in_word_3  in  16  low nibbles: {s3[3:0], s2[3:0], s1[3:0], s0[3:0]}
- sample_out  out  12  current sample
- sample_valid  out  1  sample_out is valid
- sample_ready  in  1  downstream accepts sample_out
- sample_last  out  1  sample_out is s3 (last of its packet)
- pkt_count  out  CNT_W  packets accepted since reset; wraps
- idle_drop  out  1  one-cycle pulse: an idle packet was accepted and discarded

## Operation
- Push: when in_valid && in_ready, the three words are written as one 48-bit entry into the FIFO and pkt_count increments.
- Idle packet filter: the idle packet is in_word_1 == in_word_2 == in_word_3 == 16'h0001, which is the acquisition block's idle output.
  - An idle packet is still accepted (in_ready handshake completes) and pkt_count still increments.
  - It is not written to the FIFO.
  - idle_drop pulses high in the cycle after acceptance.
- in_ready = (FIFO occupancy < PKT_DEPTH), driven from registered occupancy only.
  - There is no bypass: when the FIFO is full, in_ready stays low even if a pop occurs in the same cycle.
- Decode of the head entry, for k = 0..3: s_k = {in_word_1[4k+3:4k], in_word_2[4k+3:4k], in_word_3[4k+3:4k]}.
- Output index idx (2 bits, reset 0) selects the sample: sample_out = s_idx of the head entry.
  - sample_valid = FIFO not empty.
  - sample_last = sample_valid && idx == 3.
- Pop: on sample_valid && sample_ready, idx increments.
  - If idx was 3, the head entry is popped and idx wraps to 0.
- Simultaneous push and pop (FIFO not full) in the same cycle: occupancy is unchanged and both operations take effect.
- Pointer arithmetic: read/write pointers are log2(PKT_DEPTH) bits and wrap naturally. Occupancy is a log2(PKT_DEPTH)+1-bit register.
- A sample is never skipped or duplicated, for any sample_ready pattern.
- While sample_valid is high and sample_ready is low, sample_out and sample_last hold stable.

## Timing
- Reset values:
  - in_ready = 1
  - sample_valid = 0
  - sample_last = 0
  - sample_out = 12'h000
  - pkt_count = 0
  - idle_drop = 0
  - idx = 0
  - FIFO empty
- Reset asserted mid-packet: all state is cleared on that edge. Partially emitted samples are lost, and the FIFO is empty from the next cycle.
- Latency: a packet accepted on edge N gives sample_valid = 1 and s0 on sample_out in cycle N+1 (the cycle after edge N), when the FIFO was empty.
- Throughput: one sample per cycle with sample_ready held high, i.e. one packet per 4 cycles sustained. Input can run at 1 packet/cycle until the FIFO is full.
- A pop of the last sample at edge M frees space: in_ready = 1 from cycle M+1.
- pkt_count updates on the acceptance edge and is visible in the following cycle.

## Test plan
- Single decode: push in_word_1..3 = 16'h147A / 16'h258B / 16'h369C with sample_ready = 1 → samples 12'hABC, 12'h789, 12'h456, 12'h123 on 4 consecutive cycles; sample_last only on 12'h123; pkt_count = 1.
- Backpressure: push 3 packets back-to-back with sample_ready = 0 → in_ready drops after 2 accepts (PKT_DEPTH = 2). Then release sample_ready → 8 samples in order; third packet is accepted in the cycle after the 4th sample pops.
- Random sample_ready: random stall pattern over 100 random packets → output sequence equals the scoreboard de-interleave exactly; sample_out is stable during stalls.
- Idle filter: push 0x0001 ×3, then 16'h147A / 16'h258B / 16'h369C → idle_drop pulses once; only 4 samples emitted; pkt_count = 2.
- Reset mid-packet: after 2 of 4 samples, assert reset for 1 cycle → the next cycle shows sample_valid = 0, in_ready = 1, pkt_count = 0; a new packet decodes starting at s0.
- Counter wrap (CNT_W = 4): accept 17 packets → pkt_count = 1.
